// File: rtl/lsu_pkg.sv
// Shared LSU types: controller FSM state encoding and store byte-lane masks.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/defs.sv
// Decoder memory-access codes shared by the decoder and the load/store unit.
`ifndef LSU_DEFS_SV
`define LSU_DEFS_SV

`define MEM_NONE   4'd0
`define MEM_LOAD1  4'd1
`define MEM_LOAD2  4'd2
`define MEM_LOAD4  4'd3
`define MEM_LOAD1U 4'd4
`define MEM_LOAD2U 4'd5
`define MEM_STORE1 4'd6
`define MEM_STORE2 4'd7
`define MEM_STORE4 4'd8

`endif

// File: rtl/lsu_extend.sv
// Load alignment: shifts the addressed lane down to bit 0, then sign- or zero-extends.
`include "defs.sv"

module lsu_extend (
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [3:0]  mem_ctrl,
    output logic [31:0] rdata
);

    logic [31:0] sh;

    always_comb begin
        sh = word >> {off, 3'b000};
        case (mem_ctrl)
            `MEM_LOAD1:  rdata = {{24{sh[7]}}, sh[7:0]};
            `MEM_LOAD2:  rdata = {{16{sh[15]}}, sh[15:0]};
            `MEM_LOAD1U: rdata = {24'd0, sh[7:0]};
            `MEM_LOAD2U: rdata = {16'd0, sh[15:0]};
            default:     rdata = sh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single outstanding access on a req/gnt/rvalid bus.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of issuing them.
`include "defs.sv"

module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_i,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [4:0]  rd_o,
    output logic        reg_w_en,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        misalign_o,
    output logic [31:0] bad_addr
);

    state_t      state, state_nx;
    logic [31:0] addr_r, wdata_r, word_r, lane_wdata, ext;
    logic [3:0]  ctrl_r, strb;
    logic [4:0]  rd_r;
    logic [1:0]  off;
    logic        accept, misalign_now, capture;

    function automatic logic is_load(input logic [3:0] c);
        return c inside {`MEM_LOAD1, `MEM_LOAD2, `MEM_LOAD4, `MEM_LOAD1U, `MEM_LOAD2U};
    endfunction

    function automatic logic is_store(input logic [3:0] c);
        return c inside {`MEM_STORE1, `MEM_STORE2, `MEM_STORE4};
    endfunction

    // Byte accesses use the full offset, halfwords only addr[1], words none.
    function automatic logic [1:0] lane_off(input logic [3:0] c, input logic [1:0] a);
        case (c)
            `MEM_LOAD1, `MEM_LOAD1U, `MEM_STORE1: return a;
            `MEM_LOAD2, `MEM_LOAD2U, `MEM_STORE2: return {a[1], 1'b0};
            default:                              return 2'b00;
        endcase
    endfunction

    assign accept  = (state == ST_IDLE) && req_valid && (mem_ctrl != `MEM_NONE) && !rst;
    assign capture = bus_rvalid && (((state == ST_REQ) && bus_gnt) || (state == ST_WAIT));
    assign off     = lane_off(ctrl_r, addr_r[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [3:0] c, input logic [1:0] a);
        case (c)
            `MEM_LOAD2, `MEM_LOAD2U, `MEM_STORE2: return a[0];
            `MEM_LOAD4, `MEM_STORE4:              return a != 2'b00;
            default:                              return 1'b0;
        endcase
    endfunction

    logic mis_r;

    assign misalign_now = misaligned(mem_ctrl, addr[1:0]);

    always_ff @(posedge clk) begin
        if (accept) mis_r <= misalign_now;
    end

    assign misalign_o = done & mis_r;
    assign bad_addr   = misalign_o ? addr_r : 32'd0;
`else
    assign misalign_now = 1'b0;
    assign misalign_o   = 1'b0;
    assign bad_addr     = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Request payload is frozen at accept so the core may move on while we stall it.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_r  <= addr;
            wdata_r <= wdata;
            ctrl_r  <= mem_ctrl;
            rd_r    <= rd_i;
        end
        if (capture) word_r <= bus_rdata;
    end

    always_comb begin
        state_nx = state;
        busy     = accept;
        done     = 1'b0;
        bus_req  = 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nx = misalign_now ? ST_RESP : ST_REQ;
            ST_REQ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt)
                    state_nx = (is_store(ctrl_r) || bus_rvalid) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (bus_rvalid) state_nx = ST_RESP;
            end
            ST_RESP: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        strb       = 4'b0000;
        lane_wdata = wdata_r;
        case (ctrl_r)
            `MEM_STORE1: begin
                strb       = STRB_B << off;
                lane_wdata = {4{wdata_r[7:0]}};
            end
            `MEM_STORE2: begin
                strb       = STRB_H << off;
                lane_wdata = {2{wdata_r[15:0]}};
            end
            `MEM_STORE4: strb = STRB_W;
            default: ;
        endcase
    end

    lsu_extend u_extend (
        .word     (word_r),
        .off      (off),
        .mem_ctrl (ctrl_r),
        .rdata    (ext)
    );

    assign bus_we    = bus_req & is_store(ctrl_r);
    assign bus_addr  = bus_req ? {addr_r[31:2], 2'b00} : 32'd0;
    assign bus_wstrb = bus_req ? strb : 4'b0000;
    assign bus_wdata = bus_req ? lane_wdata : 32'd0;
    assign rdata     = done ? ext : 32'd0;
    assign rd_o      = done ? rd_r : 5'd0;
    assign reg_w_en  = done & is_load(ctrl_r) & ~misalign_o;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, randomized transactions against a
// byte-level reference model, and reset/misalignment corner sequences.
module tb_lsu_ctrl;

    localparam logic [3:0] M_LB = 4'd1, M_LH = 4'd2, M_LW = 4'd3, M_LBU = 4'd4, M_LHU = 4'd5;
    localparam logic [3:0] M_SB = 4'd6, M_SH = 4'd7, M_SW = 4'd8;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req_valid, busy, done, reg_w_en, bus_req, bus_we, bus_gnt, bus_rvalid, misalign_o;
    logic [3:0]  mem_ctrl, bus_wstrb;
    logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata, bad_addr;
    logic [4:0]  rd_i, rd_o;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_ctrl(mem_ctrl), .addr(addr),
        .wdata(wdata), .rd_i(rd_i), .busy(busy), .done(done), .rdata(rdata), .rd_o(rd_o),
        .reg_w_en(reg_w_en), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .misalign_o(misalign_o), .bad_addr(bad_addr)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          fin, req_seen, stable, busy_ok, post_done;
        logic [31:0] b_addr, b_wdata, rdata, bad;
        logic [3:0]  b_strb;
        logic        b_we, wen, mis;
        logic [4:0]  rd;
        int          lat;
    } obs_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a, wd, rw;
        int          gd, rvd;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_rdata;
        logic        e_wen;
        int          e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes, lane offset, lanes and extension.
    function automatic int sz(input logic [3:0] c);
        if (c == M_LB || c == M_LBU || c == M_SB) return 1;
        if (c == M_LH || c == M_LHU || c == M_SH) return 2;
        return 4;
    endfunction

    function automatic bit is_ld(input logic [3:0] c);
        return c >= M_LB && c <= M_LHU;
    endfunction

    function automatic int m_off(input logic [3:0] c, input logic [31:0] a);
        if (sz(c) == 4) return 0;
        if (sz(c) == 2) return int'(a & 32'd2);
        return int'(a & 32'd3);
    endfunction

    function automatic bit m_mis(input logic [3:0] c, input logic [31:0] a);
        return TRAP && ((sz(c) == 2 && a[0]) || (sz(c) == 4 && a[1:0] != 2'b00));
    endfunction

    function automatic logic [3:0] m_strb(input logic [3:0] c, input logic [31:0] a);
        logic [31:0] t;
        t = ((32'd1 << sz(c)) - 32'd1) << m_off(c, a);
        return is_ld(c) ? 4'b0000 : t[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] c, input logic [31:0] wd);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % sz(c)) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [3:0] c, input logic [31:0] a, input logic [31:0] rw);
        logic [31:0] v, mask;
        int s;
        s = sz(c);
        v = rw >> (8 * m_off(c, a));
        if (s < 4) begin
            mask = (32'd1 << (8 * s)) - 32'd1;
            v    = v & mask;
            if ((c == M_LB || c == M_LH) && v[8*s-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rw, input int gd, input int rvd,
                           input logic [4:0] rdi, input bit junk, output obs_t o);
        bit granted;
        int g, k;
        o = '{default: 0};
        o.stable = 1'b1;
        granted = 1'b0;
        g = 0;
        k = 0;
        @(negedge clk);
        req_valid = 1'b1; mem_ctrl = c; addr = a; wdata = wd; rd_i = rdi;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        o.busy_ok = busy;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            if (junk) begin
                req_valid = 1'($urandom_range(0, 1)); mem_ctrl = 4'($urandom_range(1, 8));
                addr = $urandom; wdata = $urandom; rd_i = 5'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (done) begin
                o.fin = 1'b1; o.lat = cyc; o.rdata = rdata; o.rd = rd_o; o.wen = reg_w_en;
                o.mis = misalign_o; o.bad = bad_addr; o.busy_ok = o.busy_ok & !busy;
                break;
            end
            o.busy_ok = o.busy_ok & busy;
            if (bus_req) begin
                if (!o.req_seen) begin
                    o.req_seen = 1'b1; o.b_addr = bus_addr; o.b_wdata = bus_wdata;
                    o.b_strb = bus_wstrb; o.b_we = bus_we;
                end else if (bus_addr !== o.b_addr || bus_wdata !== o.b_wdata ||
                             bus_wstrb !== o.b_strb || bus_we !== o.b_we) begin
                    o.stable = 1'b0;
                end
            end
            if (bus_req && !granted) begin
                if (g == gd) begin
                    bus_gnt = 1'b1; granted = 1'b1;
                    if (is_ld(c) && rvd == 0) begin bus_rvalid = 1'b1; bus_rdata = rw; end
                end else begin
                    g++;
                end
            end else if (granted && is_ld(c)) begin
                k++;
                if (k == rvd) begin bus_rvalid = 1'b1; bus_rdata = rw; end
            end
        end
        @(negedge clk);
        req_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'($urandom_range(0, 1));
        #1;
        o.post_done = done;
    endtask

    task automatic check_txn(input string tag, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rw, input int gd,
                             input int rvd, input logic [4:0] rdi, input obs_t o);
        bit mis;
        mis = m_mis(c, a);
        chk({tag, ".finished"}, 32'(o.fin), 32'd1);
        chk({tag, ".latency"}, 32'(o.lat), mis ? 32'd1 : 32'(2 + gd + (is_ld(c) ? rvd : 0)));
        chk({tag, ".bus_req_seen"}, 32'(o.req_seen), 32'(!mis));
        chk({tag, ".busy"}, 32'(o.busy_ok), 32'd1);
        chk({tag, ".after_done"}, 32'(o.post_done), 32'd0);
        chk({tag, ".rd_o"}, 32'(o.rd), 32'(rdi));
        chk({tag, ".reg_w_en"}, 32'(o.wen), 32'(is_ld(c) && !mis));
        chk({tag, ".misalign"}, 32'(o.mis), 32'(mis));
        chk({tag, ".bad_addr"}, o.bad, mis ? a : 32'd0);
        if (!mis) begin
            chk({tag, ".bus_addr"}, o.b_addr, a & ~32'd3);
            chk({tag, ".bus_we"}, 32'(o.b_we), 32'(!is_ld(c)));
            chk({tag, ".bus_wstrb"}, 32'(o.b_strb), 32'(m_strb(c, a)));
            chk({tag, ".stable"}, 32'(o.stable), 32'd1);
            if (is_ld(c)) chk({tag, ".rdata"}, o.rdata, m_rdata(c, a, rw));
            else          chk({tag, ".bus_wdata"}, o.b_wdata, m_wdata(c, wd));
        end
    endtask

    vec_t vecs[8];
    obs_t o;

    initial begin
        vecs[0] = '{M_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 2};
        vecs[1] = '{M_LB,  32'h203, 32'h0,        32'h80112233, 0, 3, 32'h200, 4'h0, 32'h0,        32'hFFFFFF80, 1'b1, 5};
        vecs[2] = '{M_LHU, 32'h302, 32'h0,        32'hABCD0000, 0, 0, 32'h300, 4'h0, 32'h0,        32'h0000ABCD, 1'b1, 2};
        vecs[3] = '{M_SB,  32'h401, 32'h5A,       32'h0,        0, 0, 32'h400, 4'h2, 32'h5A5A5A5A, 32'h0,        1'b0, 2};
        vecs[4] = '{M_SH,  32'h606, 32'h1234CAFE, 32'h0,        1, 0, 32'h604, 4'hC, 32'hCAFECAFE, 32'h0,        1'b0, 3};
        vecs[5] = '{M_LH,  32'h700, 32'h0,        32'h1234F00D, 0, 1, 32'h700, 4'h0, 32'h0,        32'hFFFFF00D, 1'b1, 3};
        vecs[6] = '{M_LBU, 32'h801, 32'h0,        32'h1234F0AB, 0, 0, 32'h800, 4'h0, 32'h0,        32'h000000F0, 1'b1, 2};
        vecs[7] = '{M_LW,  32'h900, 32'h0,        32'hCAFEBABE, 2, 1, 32'h900, 4'h0, 32'h0,        32'hCAFEBABE, 1'b1, 5};

        rst = 1'b1; req_valid = 1'b0; mem_ctrl = 4'd0; addr = 32'd0; wdata = 32'd0; rd_i = 5'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset.ctrl", 32'({busy, done, reg_w_en, bus_req, bus_we, bus_wstrb, misalign_o}), 32'd0);
        chk("reset.bus_addr", bus_addr, 32'd0);
        chk("reset.bus_wdata", bus_wdata, 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        chk("reset.rd_o_bad", {22'd0, rd_o, 5'd0} | bad_addr, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].c, vecs[i].a, vecs[i].wd, vecs[i].rw, vecs[i].gd, vecs[i].rvd, 5'(i + 1), 1'b0, o);
            chk($sformatf("vec%0d.latency", i), 32'(o.lat), 32'(vecs[i].e_lat));
            chk($sformatf("vec%0d.bus_addr", i), o.b_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d.bus_wstrb", i), 32'(o.b_strb), 32'(vecs[i].e_strb));
            chk($sformatf("vec%0d.reg_w_en", i), 32'(o.wen), 32'(vecs[i].e_wen));
            if (is_ld(vecs[i].c)) chk($sformatf("vec%0d.rdata", i), o.rdata, vecs[i].e_rdata);
            else                  chk($sformatf("vec%0d.bus_wdata", i), o.b_wdata, vecs[i].e_wdata);
            check_txn($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].wd, vecs[i].rw,
                      vecs[i].gd, vecs[i].rvd, 5'(i + 1), o);
        end

        // Word load at a misaligned address.
        run_txn(M_LW, 32'h502, 32'h0, 32'h11223344, 0, 0, 5'd9, 1'b0, o);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis.latency", 32'(o.lat), 32'd1);
        chk("mis.no_bus_req", 32'(o.req_seen), 32'd0);
        chk("mis.flag", 32'(o.mis), 32'd1);
        chk("mis.bad_addr", o.bad, 32'h502);
        chk("mis.reg_w_en", 32'(o.wen), 32'd0);
`else
        chk("mis.latency", 32'(o.lat), 32'd2);
        chk("mis.bus_addr", o.b_addr, 32'h500);
        chk("mis.rdata", o.rdata, 32'h11223344);
        chk("mis.flag", 32'(o.mis), 32'd0);
`endif
        check_txn("mis", M_LW, 32'h502, 32'h0, 32'h11223344, 0, 0, 5'd9, o);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  c;
            logic [31:0] a, wd, rw;
            logic [4:0]  rdi;
            int          gd, rvd;
            bit          junk;
            c = 4'($urandom_range(1, 8)); a = $urandom; wd = $urandom; rw = $urandom;
            gd = $urandom_range(0, 2); rvd = $urandom_range(0, 3); rdi = 5'($urandom);
            junk = 1'($urandom_range(0, 1));
            run_txn(c, a, wd, rw, gd, rvd, rdi, junk, o);
            check_txn($sformatf("rnd%0d", n), c, a, wd, rw, gd, rvd, rdi, o);
        end

        // Reset while waiting for read data; the late rvalid must be dropped.
        @(negedge clk);
        req_valid = 1'b1; mem_ctrl = M_LW; addr = 32'hA00; rd_i = 5'd3; bus_rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; #1;
        chk("rstwait.req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; #1;
        chk("rstwait.wait", 32'({busy, bus_req}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678; #1;
        chk("rstwait.idle", 32'({busy, bus_req, done}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_rvalid = 1'b0; #1;
            chk($sformatf("rstwait.no_done%0d", i), 32'({done, reg_w_en, busy}), 32'd0);
        end

        // Reset mid-handshake while bus_req is raised.
        @(negedge clk);
        req_valid = 1'b1; mem_ctrl = M_SW; addr = 32'hB04; wdata = 32'h55AA55AA;
        @(negedge clk);
        req_valid = 1'b0; #1;
        chk("rstreq.req", 32'(bus_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rstreq.dropped", 32'({bus_req, busy, bus_we, bus_wstrb}), 32'd0);
        chk("rstreq.bus_addr", bus_addr, 32'd0);
        @(negedge clk);
        #1;
        chk("rstreq.no_done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  input  1  single core clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req_valid  input  1  execute stage presents a memory instruction this cycle.
REQ-004 mem_ctrl  input  4  access code from the decoder (`MEM_NONE/LOAD1/LOAD2/LOAD4/LOAD1U/LOAD2U/STORE1/STORE2/STORE4`, defs.sv).
REQ-005 addr  input  32  effective byte address (ALU result).
REQ-006 wdata  input  32  store data (rs2, low bytes significant).
REQ-007 rd_i  input  5  load destination register.
REQ-008 busy  output  1  stall request to core.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  extended load result, valid with done.
REQ-011 rd_o  output  5  captured rd_i, valid with done.
REQ-012 reg_w_en  output  1  writeback enable, valid with done.
REQ-013 bus_req  output  1  bus request, held until bus_gnt.
REQ-014 bus_we  output  1  1 = store.
REQ-015 bus_addr  output  32  word address: addr with [1:0] forced to 0.
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_wstrb  output  4  byte enables (0 for loads).
REQ-018 bus_gnt  input  1  bus accepted request.
REQ-019 bus_rvalid  input  1  read data valid.
REQ-020 bus_rdata  input  32  read word.
REQ-021 misalign_o  output  1  misaligned-access exception, valid with done.
REQ-022 bad_addr  output  32  faulting byte address, valid with misalign_o.

Function
REQ-023 FSM states: IDLE, REQ, WAIT, RESP; accept = IDLE & req_valid & mem_ctrl != `MEM_NONE`.
REQ-024 IDLE -> REQ on accept; addr, wdata, mem_ctrl, rd_i registered on the accept edge.
REQ-025 REQ: bus_req=1, bus_addr/bus_we/bus_wstrb/bus_wdata stable until bus_gnt.
REQ-026 REQ & bus_gnt & store -> RESP; REQ & bus_gnt & load & !bus_rvalid -> WAIT; REQ & bus_gnt & bus_rvalid -> RESP with data captured.
REQ-027 WAIT -> RESP on bus_rvalid, bus_rdata captured; bus_req=0 in WAIT.
REQ-028 RESP lasts exactly one cycle: done=1, busy=0; RESP -> IDLE unconditionally.
REQ-029 busy = accept | state in {REQ, WAIT} (combinational from accept).
REQ-030 Minimum latency: store or zero-wait load completes 2 cycles after accept (gnt in first REQ cycle).
REQ-031 Store lanes: STORE1 wstrb = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}; STORE2 wstrb = 4'b0011 << addr[1:0], wdata = {2{wdata[15:0]}}; STORE4 wstrb = 4'hF.
REQ-032 Load extract: word >> (8*addr[1:0]); LOAD1/LOAD2 sign-extend, LOAD1U/LOAD2U zero-extend, LOAD4 as-is.
REQ-033 reg_w_en = done & load & !misalign_o; 0 for stores.
REQ-034 bus_rvalid outside REQ/WAIT and req_valid while busy are ignored.

Reset
REQ-035 rst forces IDLE; all outputs 0 the following cycle, including bus_req mid-handshake; late bus_rvalid after reset is ignored.

Configuration
REQ-036 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 issues no bus request; IDLE -> RESP directly, done=1, misalign_o=1, bad_addr=addr, reg_w_en=0.
REQ-037 Macro undefined: misalignment is not checked; halfword uses addr[1] only, word ignores addr[1:0]; misalign_o and bad_addr tied 0.

Structure
REQ-038 Package lsu_pkg holds the FSM state enum and the lane-mask constants; MEM_* codes remain in defs.sv.
REQ-039 One sub-module, lsu_extend: combinational load align/extend (word, offset, mem_ctrl -> rdata).

Verification
REQ-040 SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> wstrb=0xF, bus_addr=0x100, done 2 cycles after accept, reg_w_en=0.
REQ-041 LB addr=0x203, bus_rdata=0x80112233 with 3-cycle rvalid delay -> rdata=0xFFFFFF80, reg_w_en=1, busy held until RESP.
REQ-042 LHU addr=0x302, bus_rdata=0xABCD0000, gnt+rvalid same cycle -> REQ->RESP direct, rdata=0x0000ABCD.
REQ-043 SB addr=0x401, wdata=0x5A -> wstrb=0x2, bus_wdata=0x5A5A5A5A.
REQ-044 LW addr=0x502 with LSU_MISALIGN_TRAP_EN -> no bus_req, done next cycle, misalign_o=1, bad_addr=0x502.
REQ-045 rst asserted during WAIT then rvalid -> IDLE, bus_req=0, no done pulse.
